// File: rtl/pll_rate_ctrl.sv
// Audio PLL bring-up and rate-switch sequencer: gates CLKOUT0, pulses PLL reset,
// waits for a stable synchronised LOCK with per-attempt timeout and bounded retry.
module pll_rate_ctrl #(
  parameter int         RESET_CYCLES        = 16,
  parameter int         GATE_CYCLES         = 4,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int         MAX_RETRIES         = 3,
  parameter logic [6:0] R0_MDSEL            = 7'h1F,
  parameter logic [6:0] R0_ODSEL0           = 7'h00,
  parameter logic [6:0] R1_MDSEL            = 7'h2B,
  parameter logic [6:0] R1_ODSEL0           = 7'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       req_valid,
  input  logic       req_rate,
  output logic       req_ready,
  output logic       pll_reset,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel0,
  output logic       pll_enclk0,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       lock_lost,
  output logic       cur_rate
);

  localparam int PMAX = (RESET_CYCLES > GATE_CYCLES) ? RESET_CYCLES : GATE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int SW   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_GATE, ST_RESET, ST_WAIT_LOCK, ST_STABLE, ST_RUN, ST_FAIL
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   pcnt_reg, pcnt_next;
  logic [SW-1:0]   scnt_reg, scnt_next;
  logic [TW-1:0]   tcnt_reg, tcnt_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic            target_reg, target_next;
  logic            lost_next;
  logic            done_next;
  logic            lock_meta_reg;
  logic            lock_s;
  logic            timeout;
  logic            retry_ok;

  assign req_ready = (state_reg == ST_RUN) || (state_reg == ST_FAIL);
  assign timeout   = (tcnt_reg == TW'(LOCK_TIMEOUT_CYCLES - 1));
  assign retry_ok  = (retry_reg < RW'(MAX_RETRIES - 1));

  always_comb begin
    state_next  = state_reg;
    pcnt_next   = pcnt_reg;
    scnt_next   = scnt_reg;
    tcnt_next   = tcnt_reg;
    retry_next  = retry_reg;
    target_next = target_reg;
    lost_next   = lock_lost;
    done_next   = 1'b0;
    case (state_reg)
      ST_GATE: begin
        if (pcnt_reg == PW'(GATE_CYCLES - 1)) begin
          state_next = ST_RESET;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + PW'(1);
        end
      end
      ST_RESET: begin
        if (pcnt_reg == PW'(RESET_CYCLES - 1)) begin
          state_next = ST_WAIT_LOCK;
          pcnt_next  = '0;
          tcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + PW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        tcnt_next = tcnt_reg + TW'(1);
        if (lock_s && (LOCK_STABLE_CYCLES == 1)) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end else if (timeout) begin
          retry_next = retry_reg + RW'(1);
          pcnt_next  = '0;
          state_next = retry_ok ? ST_RESET : ST_FAIL;
        end else if (lock_s) begin
          state_next = ST_STABLE;
          scnt_next  = SW'(1);
        end
      end
      ST_STABLE: begin
        tcnt_next = tcnt_reg + TW'(1);
        // A completed stable window wins over a coincident timeout.
        if (lock_s && (scnt_reg == SW'(LOCK_STABLE_CYCLES - 1))) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end else if (timeout) begin
          retry_next = retry_reg + RW'(1);
          pcnt_next  = '0;
          state_next = retry_ok ? ST_RESET : ST_FAIL;
        end else if (lock_s) begin
          scnt_next = scnt_reg + SW'(1);
        end else begin
          scnt_next  = '0;
          state_next = ST_WAIT_LOCK;
        end
      end
      ST_RUN: begin
        // Lock loss pre-empts any request presented in the same cycle.
        if (!lock_s) begin
          lost_next  = 1'b1;
          retry_next = '0;
          pcnt_next  = '0;
          state_next = ST_GATE;
        end else if (req_valid) begin
          lost_next = 1'b0;
          if (req_rate == cur_rate) begin
            done_next = 1'b1;
          end else begin
            target_next = req_rate;
            retry_next  = '0;
            pcnt_next   = '0;
            state_next  = ST_GATE;
          end
        end
      end
      ST_FAIL: begin
        if (req_valid) begin
          target_next = req_rate;
          retry_next  = '0;
          lost_next   = 1'b0;
          pcnt_next   = '0;
          state_next  = ST_GATE;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RESET;
      pcnt_reg      <= '0;
      scnt_reg      <= '0;
      tcnt_reg      <= '0;
      retry_reg     <= '0;
      target_reg    <= 1'b0;
      lock_meta_reg <= 1'b0;
      lock_s        <= 1'b0;
      pll_reset     <= 1'b1;
      pll_enclk0    <= 1'b0;
      pll_mdsel     <= R0_MDSEL;
      pll_odsel0    <= R0_ODSEL0;
      cur_rate      <= 1'b0;
      ready         <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      lock_lost     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pcnt_reg      <= pcnt_next;
      scnt_reg      <= scnt_next;
      tcnt_reg      <= tcnt_next;
      retry_reg     <= retry_next;
      target_reg    <= target_next;
      lock_meta_reg <= pll_lock;
      lock_s        <= lock_meta_reg;
      pll_reset     <= (state_next == ST_RESET) || (state_next == ST_FAIL);
      pll_enclk0    <= (state_next == ST_RUN);
      ready         <= (state_next == ST_RUN);
      busy          <= (state_next == ST_GATE) || (state_next == ST_RESET) ||
                       (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE);
      error         <= (state_next == ST_FAIL);
      done          <= done_next;
      lock_lost     <= lost_next;
      // Selects move only together with a high pll_reset.
      if (state_next == ST_RESET) begin
        cur_rate   <= target_next;
        pll_mdsel  <= target_next ? R1_MDSEL : R0_MDSEL;
        pll_odsel0 <= target_next ? R1_ODSEL0 : R0_ODSEL0;
      end
    end
  end

endmodule
